sobel_gradient_pipe: RTL and testbench
======================================

// Module: sobel_gradient_pipe
// PURPOSE
//  Downstream stage of the 3x3 window loader. Consumes one 9-pixel window per enabled cycle.
//  Computes Sobel Gx/Gy, |Gx|+|Gy| magnitude, saturation and border masking in a 3-stage pipeline.
//  Emits one edge pixel per window, carrying the centre coordinate.
//  A small FSM drains the pipeline after the last window and pulses Done.
// PARAMETERS
//  IMG_WIDTH   256  pixels per row; coordinate width is fixed at 8 bits
//  IMG_HEIGHT  256  rows per frame
//  THRESHOLD   100  binarisation level; used only when SOBEL_THRESHOLD_EN is defined
// PORTS
//  CLK         in   1  clock; all state updates on rising edge
//  Reset       in   1  synchronous reset, active-low
//  Enable      in   1  global advance; pipe and FSM hold when 0
//  isReady     in   1  window on DataIn0..8 is valid
//  isEnd       in   1  current window is the last of the frame
//  DataIn0..8  in   8  window pixels, row-major; 0 = top-left, 4 = centre, 8 = bottom-right (newest)
//  In_Row      in   8  row of the newest pixel (DataIn8)
//  In_Column   in   8  column of the newest pixel (DataIn8)
//  EdgeOut     out  8  edge magnitude, or 0/255 when thresholded
//  Out_Row     out  8  centre row = In_Row-1
//  Out_Column  out  8  centre column = In_Column-1
//  Valid       out  1  EdgeOut, Out_Row and Out_Column are valid this cycle
//  Busy        out  1  FSM in RUN or FLUSH
//  Done        out  1  one-cycle pulse once the final window has exited
// BEHAVIOUR
//  Reset (Reset=0 at a clock edge): all pipe registers, outputs and valid bits = 0; FSM = IDLE.
//   A reset mid-frame drops in-flight windows; no Done is generated.
//  Acceptance: a window is accepted when Enable=1 and isReady=1.
//  Enable=0 freezes every register, including Valid and Done; outputs hold their values.
//  Pipeline and latency: 3 enabled cycles from acceptance to Valid=1.
//   S1: per-column and per-row weighted sums (P0+2P3+P6, P2+2P5+P8, P0+2P1+P2, P6+2P7+P8),
//       each 10-bit unsigned.
//   S2: Gx = right - left, Gy = bottom - top, each 11-bit signed (range -1020..1020);
//       take abs() of each into 10 bits.
//   S3: mag = |Gx|+|Gy| (11-bit, max 2040); EdgeOut = (mag>255) ? 255 : mag[7:0].
//  Border: windows with In_Row<2 or In_Column<2 straddle the image edge or a row wrap.
//   They still flow through the pipe with Valid=1, but EdgeOut is forced to 0.
//   The coordinate subtraction is still performed and wraps modulo 256.
//  Valid is a per-stage bit shifted along with the data. Bubbles (isReady=0) produce Valid=0.
//  FSM:
//   IDLE  -> RUN on the first accepted window.
//   RUN   -> FLUSH when the accepted window has isEnd=1.
//   FLUSH -> counts 3 enabled cycles; windows arriving in FLUSH are ignored.
//   FLUSH -> DONE when the count completes; the last Valid coincides with the DONE entry edge.
//   DONE  -> Done=1 for one cycle, then IDLE.
//  Simultaneous events: isEnd on the first window (IDLE) goes straight to FLUSH.
//   isEnd while isReady=0 is ignored.
// CONFIGURATION
//  SOBEL_THRESHOLD_EN defined: EdgeOut = (mag >= THRESHOLD) ? 8'd255 : 8'd0.
//   This is applied in S3 after the border mask; masked pixels stay 0.
//  Not defined: the saturated magnitude is output and THRESHOLD is unused.
//  Latency is 3 in both builds.
// TESTING
//  1 Flat window (all pixels 50) at row 5, col 5 -> 3 cycles later Valid=1, EdgeOut=0,
//    Out_Row=4, Out_Column=4.
//  2 Vertical edge (col0=0, col2=255, centre column 128) -> Gx=1020, Gy=0, EdgeOut=255.
//    Gentle edge (col2=20, col0=0) -> Gx=80, EdgeOut=80.
//  3 Border window at In_Column=1 with a strong edge -> Valid=1, EdgeOut=0, Out_Column=0.
//  4 Stall: accept a window, drop Enable for 4 cycles, raise it -> Valid appears after
//    3 enabled cycles; outputs unchanged during the stall.
//  5 Stream 10 windows, isEnd on the 10th -> 10 Valid pulses, Done pulses once
//    1 cycle after the last Valid, Busy=0 afterwards.
//    Reset asserted at window 6 -> no further Valid, no Done.
//  6 SOBEL_THRESHOLD_EN, THRESHOLD=100: magnitudes 99 / 100 / 2040 -> EdgeOut 0 / 255 / 255.

Source files
------------

// File: rtl/sobel_gradient_pipe.sv
// sobel_gradient_pipe
//   Downstream stage of the 3x3 window loader. Takes one 9-pixel window per
//   accepted cycle and computes the Sobel gradient magnitude |Gx|+|Gy| in a
//   3-stage pipeline. Windows at the image border are masked to 0. Each output
//   carries the centre coordinate of its window. A small FSM drains the pipe
//   after the last window of a frame and pulses Done.
//
//   Optional build macro SOBEL_THRESHOLD_EN: the output is binarised to 0/255
//   against THRESHOLD instead of carrying the saturated magnitude.
//
// Ports
//   CLK                 clock, rising edge
//   Reset               synchronous reset, active-low
//   Enable              global advance; pipe and FSM hold while low
//   isReady             window on DataIn0..8 is valid
//   isEnd               current window is the last of the frame
//   DataIn0..DataIn8    window pixels, row-major (4 = centre, 8 = newest)
//   In_Row, In_Column   coordinate of the newest pixel (DataIn8)
//   EdgeOut             edge value (magnitude, or 0/255 when thresholded)
//   Out_Row, Out_Column centre coordinate of the window (input minus 1)
//   Valid               EdgeOut/Out_Row/Out_Column valid
//   Busy                FSM in RUN or FLUSH
//   Done                one-cycle pulse after the final window has exited
module sobel_gradient_pipe #(
  parameter int unsigned IMG_WIDTH  = 256,
  parameter int unsigned IMG_HEIGHT = 256
`ifdef SOBEL_THRESHOLD_EN
  ,
  parameter int unsigned THRESHOLD  = 100
`endif
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       isReady,
  input  logic       isEnd,
  input  logic [7:0] DataIn0,
  input  logic [7:0] DataIn1,
  input  logic [7:0] DataIn2,
  input  logic [7:0] DataIn3,
  input  logic [7:0] DataIn4,
  input  logic [7:0] DataIn5,
  input  logic [7:0] DataIn6,
  input  logic [7:0] DataIn7,
  input  logic [7:0] DataIn8,
  input  logic [7:0] In_Row,
  input  logic [7:0] In_Column,
  output logic [7:0] EdgeOut,
  output logic [7:0] Out_Row,
  output logic [7:0] Out_Column,
  output logic       Valid,
  output logic       Busy,
  output logic       Done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e     state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic       done_q, done_d;
  logic       busy_d;
  logic       accept;

  // Stage 1: weighted column/row sums
  logic [9:0] left_q, right_q, top_q, bot_q;
  logic [9:0] left_d, right_d, top_d, bot_d;
  logic       v1_q, border1_q, border_d;
  logic [7:0] row1_q, col1_q;

  // Stage 2: absolute gradients
  logic [10:0] gx, gy;
  logic [9:0]  ax_q, ay_q, ax_d, ay_d;
  logic        v2_q, border2_q;
  logic [7:0]  row2_q, col2_q;

  // Stage 3: magnitude, saturation / threshold, border mask
  logic [10:0] mag;
  logic [7:0]  edge_val, edge_d;
  logic [7:0]  edge_q, orow_q, ocol_q;
  logic        valid_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
    end else if (Enable) begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // The FLUSH count includes the edge that entered FLUSH, so two more enabled
  // edges bring the last accepted window out of S3 exactly as DONE is entered.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = isEnd ? FLUSH : RUN;
          flush_cnt_d = '0;
        end
      end
      RUN: begin
        if (accept && isEnd) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 2'd1) state_d = DONE;
        else                     flush_cnt_d = flush_cnt_q + 2'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Windows are only taken in IDLE/RUN; anything offered during FLUSH/DONE is dropped.
  always_comb begin
    accept = Enable && isReady && ((state_q == IDLE) || (state_q == RUN));
    busy_d = (state_q == RUN) || (state_q == FLUSH);
    done_d = (state_q == DONE);
  end

  // ---------------- Stage 1 ----------------
  // Columns/rows past the configured image size are treated like border windows.
  always_comb begin
    left_d   = {2'b00, DataIn0} + {1'b0, DataIn3, 1'b0} + {2'b00, DataIn6};
    right_d  = {2'b00, DataIn2} + {1'b0, DataIn5, 1'b0} + {2'b00, DataIn8};
    top_d    = {2'b00, DataIn0} + {1'b0, DataIn1, 1'b0} + {2'b00, DataIn2};
    bot_d    = {2'b00, DataIn6} + {1'b0, DataIn7, 1'b0} + {2'b00, DataIn8};
    border_d = (In_Row < 8'd2) || (In_Column < 8'd2) ||
               (32'(In_Row) >= IMG_HEIGHT) || (32'(In_Column) >= IMG_WIDTH);
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      left_q    <= '0;
      right_q   <= '0;
      top_q     <= '0;
      bot_q     <= '0;
      v1_q      <= 1'b0;
      border1_q <= 1'b0;
      row1_q    <= '0;
      col1_q    <= '0;
    end else if (Enable) begin
      left_q    <= left_d;
      right_q   <= right_d;
      top_q     <= top_d;
      bot_q     <= bot_d;
      v1_q      <= accept;
      border1_q <= border_d;
      row1_q    <= In_Row - 8'd1;
      col1_q    <= In_Column - 8'd1;
    end
  end

  // ---------------- Stage 2 ----------------
  // 11-bit two's complement differences; |x| <= 1020 so the abs fits 10 bits.
  always_comb begin
    gx   = {1'b0, right_q} - {1'b0, left_q};
    gy   = {1'b0, bot_q} - {1'b0, top_q};
    ax_d = gx[10] ? 10'(11'd0 - gx) : gx[9:0];
    ay_d = gy[10] ? 10'(11'd0 - gy) : gy[9:0];
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      ax_q      <= '0;
      ay_q      <= '0;
      v2_q      <= 1'b0;
      border2_q <= 1'b0;
      row2_q    <= '0;
      col2_q    <= '0;
    end else if (Enable) begin
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      v2_q      <= v1_q;
      border2_q <= border1_q;
      row2_q    <= row1_q;
      col2_q    <= col1_q;
    end
  end

  // ---------------- Stage 3 ----------------
  always_comb begin
    mag = {1'b0, ax_q} + {1'b0, ay_q};
`ifdef SOBEL_THRESHOLD_EN
    edge_val = (32'(mag) >= THRESHOLD) ? 8'd255 : 8'd0;
`else
    edge_val = (mag > 11'd255) ? 8'd255 : mag[7:0];
`endif
    edge_d = border2_q ? 8'd0 : edge_val;
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      edge_q  <= '0;
      orow_q  <= '0;
      ocol_q  <= '0;
      valid_q <= 1'b0;
    end else if (Enable) begin
      edge_q  <= edge_d;
      orow_q  <= row2_q;
      ocol_q  <= col2_q;
      valid_q <= v2_q;
    end
  end

  assign EdgeOut    = edge_q;
  assign Out_Row    = orow_q;
  assign Out_Column = ocol_q;
  assign Valid      = valid_q;
  assign Busy       = busy_d;
  assign Done       = done_q;

endmodule

// File: tb/tb_sobel_gradient_pipe.sv
// Testbench for sobel_gradient_pipe: table of windows with hand-computed
// expected edge values, scoreboard queue filled at drive time and drained
// when Valid appears, plus stall, drain/Done and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_sobel_gradient_pipe;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       Reset, Enable, isReady, isEnd;
  logic [7:0] px [9];
  logic [7:0] In_Row, In_Column;
  logic [7:0] EdgeOut, Out_Row, Out_Column;
  logic       Valid, Busy, Done;

  sobel_gradient_pipe dut (
    .CLK(CLK), .Reset(Reset), .Enable(Enable), .isReady(isReady), .isEnd(isEnd),
    .DataIn0(px[0]), .DataIn1(px[1]), .DataIn2(px[2]),
    .DataIn3(px[3]), .DataIn4(px[4]), .DataIn5(px[5]),
    .DataIn6(px[6]), .DataIn7(px[7]), .DataIn8(px[8]),
    .In_Row(In_Row), .In_Column(In_Column),
    .EdgeOut(EdgeOut), .Out_Row(Out_Row), .Out_Column(Out_Column),
    .Valid(Valid), .Busy(Busy), .Done(Done)
  );

  typedef struct packed {
    logic [8:0][7:0] p;
    logic [7:0]      row, col;
    logic [7:0]      e_mag;   // expected with plain saturated magnitude
    logic [7:0]      e_thr;   // expected with THRESHOLD=100 binarisation
  } vec_t;

  typedef struct packed {
    logic [7:0] e, r, c;
  } exp_t;

  exp_t sb[$];
  exp_t mon_x;
  vec_t vt[14];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, valid_cnt = 0, done_cnt = 0;
  int last_valid_cyc = -1, done_cyc = -1;
  int v0, d0;
  logic en_last = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mkv(input logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7, a8,
                               input logic [7:0] r, c, em, et);
    vec_t v;
    v.p[0] = a0; v.p[1] = a1; v.p[2] = a2;
    v.p[3] = a3; v.p[4] = a4; v.p[5] = a5;
    v.p[6] = a6; v.p[7] = a7; v.p[8] = a8;
    v.row = r; v.col = c; v.e_mag = em; v.e_thr = et;
    return v;
  endfunction

  function automatic logic [7:0] exp_edge(input vec_t v);
`ifdef SOBEL_THRESHOLD_EN
    return v.e_thr;
`else
    return v.e_mag;
`endif
  endfunction

  function automatic exp_t exp_of(input vec_t v);
    exp_t x;
    x.e = exp_edge(v);
    x.r = v.row - 8'd1;
    x.c = v.col - 8'd1;
    return x;
  endfunction

  // Scoreboard drain: pop on every Valid that follows an enabled edge.
  always @(posedge CLK) en_last <= Enable;

  always @(negedge CLK) begin
    cyc++;
    if (Valid && en_last) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_x = sb.pop_front();
        check("edge_out",   int'(EdgeOut),    int'(mon_x.e));
        check("out_row",    int'(Out_Row),    int'(mon_x.r));
        check("out_column", int'(Out_Column), int'(mon_x.c));
      end
    end
    if (Done && en_last) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic put_win(input vec_t v, input logic last, input logic expect_acc);
    @(negedge CLK);
    for (int i = 0; i < 9; i++) px[i] = v.p[i];
    In_Row    = v.row;
    In_Column = v.col;
    isReady   = 1'b1;
    isEnd     = last;
    if (expect_acc) sb.push_back(exp_of(v));
  endtask

  task automatic idle_cyc(input int n, input logic end_flag);
    repeat (n) begin
      @(negedge CLK);
      isReady = 1'b0;
      isEnd   = end_flag;
    end
  endtask

  initial begin
    //            P0  P1  P2  P3  P4  P5  P6  P7  P8   row  col  mag  thr
    vt[0]  = mkv( 50, 50, 50, 50, 50, 50, 50, 50, 50,   5,   5,   0,   0); // flat
    vt[1]  = mkv(  0,128,255,  0,128,255,  0,128,255,  10,  10, 255, 255); // Gx=1020
    vt[2]  = mkv(  0, 10, 20,  0, 10, 20,  0, 10, 20,  10,  10,  80,   0); // Gx=80
    vt[3]  = mkv(  0,128,255,  0,128,255,  0,128,255,  10,   1,   0,   0); // column border
    vt[4]  = mkv(  0,128,255,  0,128,255,  0,128,255,   0,   0,   0,   0); // corner, coords wrap
    vt[5]  = mkv(  0,  0,  0,  0,  0,  0, 30, 30, 30,  20,  30, 120, 255); // Gy=120
    vt[6]  = mkv( 40,  0,  0,  0,  0,  0,  0,  0,  0,  30,  40,  80,   0); // Gx=Gy=-40
    vt[7]  = mkv(  0,  0,  0,  0,  0,  0,  0,  0, 60,  40,  50, 120, 255); // Gx=Gy=60
    vt[8]  = mkv(  0,  0,  0,  0,  0,127,  0,  0,  0,  50,  60, 254, 255); // just below sat
    vt[9]  = mkv(  0,  0,  0,  0,  0,127,  0,  0,  1,  60,  70, 255, 255); // mag 256 saturates
    vt[10] = mkv(  0,  0,  0,  0,  0, 50,  0,  0,  0,  70,  80, 100, 255); // mag 100
    vt[11] = mkv(  0,  0,  0,  0,  0, 49,  0,  0,  0,  80,  90,  98,   0); // mag 98
    vt[12] = mkv(  0,  0,255,  0,  0,255,255,255,255, 255, 255, 255, 255); // mag 1530
    vt[13] = mkv(  0,128,255,  0,128,255,  0,128,255,   1, 200,   0,   0); // row border

    Reset = 1'b0; Enable = 1'b1; isReady = 1'b0; isEnd = 1'b0;
    In_Row = '0; In_Column = '0;
    for (int i = 0; i < 9; i++) px[i] = 8'hAA;

    repeat (3) @(negedge CLK);
    check("reset_valid",   int'(Valid),      0);
    check("reset_edge",    int'(EdgeOut),    0);
    check("reset_row",     int'(Out_Row),    0);
    check("reset_col",     int'(Out_Column), 0);
    check("reset_busy",    int'(Busy),       0);
    check("reset_done",    int'(Done),       0);
    Reset = 1'b1;

    // Stream the table with isEnd on the last window; one bubble carries isEnd
    // (must be ignored) and a window offered during FLUSH must be dropped.
    v0 = valid_cnt; d0 = done_cnt;
    for (int i = 0; i < 14; i++) begin
      put_win(vt[i], (i == 13), 1'b1);
      if (i == 1) check("busy_run", int'(Busy), 1);
      if (i == 6) idle_cyc(1, 1'b1);
    end
    put_win(vt[1], 1'b0, 1'b0);
    idle_cyc(8, 1'b0);
    check("stream_valid_cnt", valid_cnt - v0, 14);
    check("stream_done_cnt",  done_cnt - d0,  1);
    check("done_after_last_valid", done_cyc - last_valid_cyc, 1);
    check("stream_busy_end", int'(Busy), 0);
    check("stream_sb_empty", sb.size(), 0);

    // Stall: A reaches the output, then Enable drops for 4 cycles with B in S2.
    d0 = done_cnt;
    put_win(vt[1], 1'b0, 1'b1);
    put_win(vt[2], 1'b1, 1'b1);
    idle_cyc(1, 1'b0);
    @(negedge CLK);
    Enable = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      check("stall_valid", int'(Valid),   1);
      check("stall_edge",  int'(EdgeOut), int'(exp_edge(vt[1])));
      check("stall_row",   int'(Out_Row), 9);
      check("stall_busy",  int'(Busy),    1);
    end
    Enable = 1'b1;
    @(negedge CLK);
    check("post_stall_valid", int'(Valid),   1);
    check("post_stall_edge",  int'(EdgeOut), int'(exp_edge(vt[2])));
    check("post_stall_done",  int'(Done),    0);
    idle_cyc(6, 1'b0);
    check("stall_done_cnt", done_cnt - d0, 1);
    check("stall_busy_end", int'(Busy), 0);
    check("stall_sb_empty", sb.size(), 0);

    // Mid-frame reset on the 6th window: windows 4 and 5 are dropped, no Done.
    v0 = valid_cnt; d0 = done_cnt;
    for (int i = 0; i < 5; i++) put_win(vt[5 + i], 1'b0, 1'b1);
    put_win(vt[10], 1'b0, 1'b0);
    Reset = 1'b0;
    @(negedge CLK);
    check("reset_mid_valid", int'(Valid), 0);
    check("reset_mid_inflight", sb.size(), 2);
    sb.delete();
    Reset   = 1'b1;
    isReady = 1'b0;
    idle_cyc(8, 1'b0);
    check("reset_mid_valid_cnt", valid_cnt - v0, 3);
    check("reset_mid_done_cnt",  done_cnt - d0,  0);
    check("reset_mid_busy",      int'(Busy),     0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
